// File: rtl/hamming_pkg.sv
// Shared types and constants for the 7-bit Hamming transmit path.
package hamming_pkg;

   // Transmit frame sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // Codeword length; positions run 1..CW_LEN.
   localparam int CW_LEN = 7;

   // Parity bit positions inside the codeword.
   localparam logic [2:0] P1_POS = 3'd1;
   localparam logic [2:0] P2_POS = 3'd2;
   localparam logic [2:0] P4_POS = 3'd4;

   // Codeword position of data bit D[i], indexed by i = 1..4.
   localparam logic [2:0] DATA_POS [1:4] = '{3'd3, 3'd5, 3'd6, 3'd7};

endpackage

// File: rtl/hamming_7bit_encoder.sv
// Combinational Hamming(7,4) encoder with optional single-bit error injection.
// Also serves as a golden model for the downstream corrector's bench.
module hamming_7bit_encoder
   import hamming_pkg::*;
(
   input  logic [4:1]      D,
   input  logic [2:0]      ERR_POS,
   output logic [CW_LEN:1] C
);

   // Place data bits, derive parity, then flip the selected position if asked.
   always_comb begin
      C = '0;
      C[DATA_POS[1]] = D[1];
      C[DATA_POS[2]] = D[2];
      C[DATA_POS[3]] = D[3];
      C[DATA_POS[4]] = D[4];
      // Each parity bit covers the positions whose index has its bit set.
      C[P1_POS] = D[1] ^ D[2] ^ D[4];
      C[P2_POS] = D[1] ^ D[3] ^ D[4];
      C[P4_POS] = D[2] ^ D[3] ^ D[4];
      // Position 0 means no injection; only one bit is ever inverted.
      if (ERR_POS != 3'd0) begin
         C[ERR_POS] = ~C[ERR_POS];
      end
   end

endmodule

// File: rtl/hamming_7bit_tx.sv
// Hamming(7,4) serial transmitter: accepts a nibble, encodes it and sends
// start bit, C[1]..C[7], stop bit, each lasting BAUD_DIV clock cycles.
module hamming_7bit_tx
   import hamming_pkg::*;
#(
   parameter int BAUD_DIV = 4
)
(
   input  logic            CLK,
   input  logic            RST,
   input  logic [4:1]      D,
   input  logic            VALID,
   input  logic [2:0]      ERR_POS,
   output logic            READY,
   output logic            TX,
   output logic            BUSY,
   output logic [CW_LEN:1] C,
   output state_t          DBG_STATE
);

   // Handshake: a nibble transfers on a rising edge where VALID && READY.
   // D and ERR_POS are sampled only on that edge. VALID while READY=0 is
   // dropped (no queuing), and VALID is ignored while RST is high.

   localparam int            TW   = $clog2(BAUD_DIV + 1);
   localparam logic [TW-1:0] TMAX = TW'(BAUD_DIV - 1);

   state_t            state;
   logic [TW-1:0]     timer;
   logic [2:0]        idx;
   logic [CW_LEN:1]   cw_next;
   logic              bit_end;

   hamming_7bit_encoder u_enc (
      .D       (D),
      .ERR_POS (ERR_POS),
      .C       (cw_next)
   );

   assign bit_end   = (timer == TMAX);
   assign DBG_STATE = state;

   // Frame sequencer with registered TX, READY, BUSY and codeword.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         timer <= '0;
         idx   <= '0;
         TX    <= 1'b1;
         READY <= 1'b1;
         BUSY  <= 1'b0;
         C     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (VALID && READY) begin
                  state <= START;
                  timer <= '0;
                  TX    <= 1'b0;
                  READY <= 1'b0;
                  BUSY  <= 1'b1;
                  C     <= cw_next;
               end
            end
            START: begin
               if (bit_end) begin
                  state <= DATA;
                  timer <= '0;
                  idx   <= 3'd1;
                  TX    <= C[P1_POS];
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  timer <= '0;
                  if (idx == 3'd7) begin
                     state <= STOP;
                     TX    <= 1'b1;
                  end else begin
                     idx <= idx + 3'd1;
                     TX  <= C[idx + 3'd1];
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  state <= IDLE;
                  timer <= '0;
                  idx   <= '0;
                  TX    <= 1'b1;
                  READY <= 1'b1;
                  BUSY  <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               TX    <= 1'b1;
               READY <= 1'b1;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_7bit_tx.sv
// Directed bench for hamming_7bit_tx: one instance at BAUD_DIV=4 for
// frame timing/reset/ignore checks, one at BAUD_DIV=1 for the full sweep.
module tb_hamming_7bit_tx;
   import hamming_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // BAUD_DIV = 4 instance
   logic [3:0] d = '0;
   logic       valid = 1'b0;
   logic [2:0] err_pos = '0;
   logic       ready, tx, busy;
   logic [7:1] c;
   state_t     dbg_state;

   hamming_7bit_tx #(.BAUD_DIV(4)) dut (
      .CLK(clk), .RST(rst), .D(d), .VALID(valid), .ERR_POS(err_pos),
      .READY(ready), .TX(tx), .BUSY(busy), .C(c), .DBG_STATE(dbg_state)
   );

   // BAUD_DIV = 1 instance
   logic [3:0] d1 = '0;
   logic       valid1 = 1'b0;
   logic [2:0] err_pos1 = '0;
   logic       ready1, tx1, busy1;
   logic [7:1] c1;
   state_t     dbg_state1;

   hamming_7bit_tx #(.BAUD_DIV(1)) dut1 (
      .CLK(clk), .RST(rst), .D(d1), .VALID(valid1), .ERR_POS(err_pos1),
      .READY(ready1), .TX(tx1), .BUSY(busy1), .C(c1), .DBG_STATE(dbg_state1)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference encoder, written straight from the position equations.
   function automatic logic [7:1] model_enc(input logic [3:0] dv, input logic [2:0] ev);
      logic [7:1] m;
      m = '0;
      m[3] = dv[0]; m[5] = dv[1]; m[6] = dv[2]; m[7] = dv[3];
      m[1] = m[3] ^ m[5] ^ m[7];
      m[2] = m[3] ^ m[6] ^ m[7];
      m[4] = m[5] ^ m[6] ^ m[7];
      if (ev != 3'd0) m[ev] = ~m[ev];
      return m;
   endfunction

   // Reference corrector: syndrome and corrected nibble.
   task automatic model_dec(input logic [7:1] r, output logic [2:0] syn, output logic [3:0] dv);
      logic [7:1] f;
      syn[0] = r[1] ^ r[3] ^ r[5] ^ r[7];
      syn[1] = r[2] ^ r[3] ^ r[6] ^ r[7];
      syn[2] = r[4] ^ r[5] ^ r[6] ^ r[7];
      f = r;
      if (syn != 3'd0) f[syn] = ~f[syn];
      dv = {f[7], f[6], f[5], f[3]};
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input bit which);
      logic r;
      r = which ? ready1 : ready;
      for (int i = 0; i < 200 && !r; i++) begin
         tick();
         r = which ? ready1 : ready;
      end
      check("wait_ready", 32'(r), 32'd1);
   endtask

   // Send one frame on the BAUD_DIV=4 instance, checking every TX cycle.
   // With poke set, a D=1111 pulse is offered mid-frame and must be dropped.
   task automatic run_frame(input logic [3:0] dv, input logic [2:0] ev,
                            input logic [7:1] exp_c, input bit poke,
                            output logic [7:1] rx);
      logic [8:0] fr;
      fr = {1'b1, exp_c, 1'b0};
      rx = '0;
      wait_ready(1'b0);
      d = dv; err_pos = ev; valid = 1'b1;
      tick();
      valid = 1'b0;
      check("c_on_accept", 32'(c), 32'(exp_c));
      check("busy_on_accept", 32'(busy), 32'd1);
      check("ready_on_accept", 32'(ready), 32'd0);
      for (int f = 0; f < 9; f++) begin
         for (int j = 0; j < 4; j++) begin
            check($sformatf("tx_f%0d_c%0d", f, j), 32'(tx), 32'(fr[f[3:0]]));
            if (j == 1 && f >= 1 && f <= 7) rx[f[2:0]] = tx;
            if (f == 8 && j == 3) check("ready_last_cycle", 32'(ready), 32'd0);
            if (poke && f == 4 && j == 1) begin
               d = 4'b1111; err_pos = 3'd0; valid = 1'b1;
            end
            tick();
            valid = 1'b0;
         end
      end
      check("ready_end", 32'(ready), 32'd1);
      check("busy_end", 32'(busy), 32'd0);
      check("c_held", 32'(c), 32'(exp_c));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:1] rx;
      logic [2:0] syn;
      logic [3:0] dd;
      logic [7:1] ec;
      int last_k;

      // Reset and idle
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("dbg_state_reset", 32'(dbg_state), 32'(IDLE));
      for (int i = 0; i < 20; i++) begin
         check("idle_tx", 32'(tx), 32'd1);
         check("idle_ready", 32'(ready), 32'd1);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_c", 32'(c), 32'd0);
         tick();
      end

      // D=1011, no injection: C=1010101, TX 0,1,0,1,0,1,0,1,1
      run_frame(4'b1011, 3'd0, 7'b1010101, 1'b0, rx);
      check("rx_1011", 32'(rx), 32'h55);

      // D=0000, inject at 3: C=0000100; corrector flags pos 3 and restores 0000
      run_frame(4'b0000, 3'd3, 7'b0000100, 1'b0, rx);
      model_dec(rx, syn, dd);
      check("dec_syn_pos3", 32'(syn), 32'd3);
      check("dec_data_0000", 32'(dd), 32'd0);

      // BAUD_DIV=1 sweep: every nibble x every ERR_POS, VALID held high
      wait_ready(1'b1);
      last_k = 0;
      for (int n = 0; n < 128; n++) begin
         if (n > 0) check("b1_ready_idle", 32'(ready1), 32'd1);
         d1 = 4'(n); err_pos1 = 3'(n >> 4); valid1 = 1'b1;
         exp_q.push_back(4'(n));
         ec = model_enc(4'(n), 3'(n >> 4));
         tick();
         if (n > 0) check("b1_spacing", 32'(cyc - last_k), 32'd10);
         last_k = cyc;
         check("b1_start", 32'(tx1), 32'd0);
         for (int i = 1; i <= 7; i++) begin
            tick();
            rx[i[2:0]] = tx1;
         end
         tick();
         check("b1_stop", 32'(tx1), 32'd1);
         check("b1_c", 32'(c1), 32'(ec));
         model_dec(rx, syn, dd);
         check("b1_syn", 32'(syn), 32'(n >> 4));
         check("b1_data", 32'(dd), 32'(exp_q.pop_front()));
         tick();
      end
      valid1 = 1'b0;
      tick();

      // Reset during DATA bit 4 (VALID also high, must be ignored)
      wait_ready(1'b0);
      d = 4'b1011; err_pos = 3'd0; valid = 1'b1;
      tick();
      valid = 1'b0;
      repeat (17) tick();
      check("pre_rst_bit4", 32'(tx), 32'd0);
      check("pre_rst_state", 32'(dbg_state), 32'(DATA));
      rst = 1'b1; valid = 1'b1;
      tick();
      rst = 1'b0; valid = 1'b0;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_c", 32'(c), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));

      // Clean frame after the abort: D=0110 -> C=0110011
      run_frame(4'b0110, 3'd0, 7'b0110011, 1'b0, rx);
      check("rx_0110", 32'(rx), 32'h33);

      // VALID poked mid-frame with D=1111: D=0101, ERR_POS=6 -> C=0001101
      run_frame(4'b0101, 3'd6, 7'b0001101, 1'b1, rx);
      check("rx_poke", 32'(rx), 32'h0D);
      for (int i = 0; i < 40; i++) begin
         check("no_extra_tx", 32'(tx), 32'd1);
         check("no_extra_busy", 32'(busy), 32'd0);
         tick();
      end
      check("c_after_poke", 32'(c), 32'h0D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so a stuck handshake can never hang the run.
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
